// File: rtl/music_box_state_scheduler.sv
// music_box_state_scheduler: debounces four keys and launches one state
// module at a time over currentState, returning to DoNothing (0) when done.
// Ports: clock_50Mhz, reset (sync, high), button_n[3:0] (active-low keys),
//   state_complete[7:0] -> currentState[4:0], busy, tick_1khz, debugString[31:0]
// Optional watchdog per state: define STATE_TIMEOUT_EN.
module music_box_state_scheduler #(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1000,
  parameter int DEBOUNCE_MS = 20,
  parameter int HOLDOFF_MS  = 3,
  parameter int TIMEOUT_MS  = 60000
) (
  input  logic        clock_50Mhz,
  input  logic        reset,
  input  logic [3:0]  button_n,
  input  logic [7:0]  state_complete,
  output logic [4:0]  currentState,
  output logic        busy,
  output logic        tick_1khz,
  output logic [31:0] debugString
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DW  = $clog2(DIV);
  localparam int DBW =
    (DEBOUNCE_MS > 1) ? $clog2(DEBOUNCE_MS) : 1;
  localparam int HW  =
    (HOLDOFF_MS > 0) ? $clog2(HOLDOFF_MS + 1) : 1;

  localparam logic [DW-1:0]  DIV_LAST  = DW'(DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_MS - 1);
  localparam logic [HW-1:0]  HOLD_INIT = HW'(HOLDOFF_MS);

  typedef enum logic [1:0] {IDLE, HOLD, RUN} fsm_t;

  logic [DW-1:0]  div_cnt;
  logic [3:0]     key_s1, key_s2;
  logic [7:0]     sc_s1, sc_s2;
  logic [3:0]     key_acc, db_hit, press_evt;
  logic [DBW-1:0] db_cnt [4];
  logic [4:0]     launch_state;
  fsm_t           fsm;
  logic [HW-1:0]  hold_cnt;
  logic [14:0]    ms_cnt;
  logic           run_exit, wd_hit, timeout_flag;

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      div_cnt   <= '0;
      tick_1khz <= 1'b0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt   <= '0;
      tick_1khz <= 1'b1;
    end else begin
      div_cnt   <= div_cnt + 1'b1;
      tick_1khz <= 1'b0;
    end
  end

  // keys are inverted here so 1 means pressed from now on
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      key_s1 <= '0;
      key_s2 <= '0;
      sc_s1  <= '0;
      sc_s2  <= '0;
    end else begin
      key_s1 <= ~button_n;
      key_s2 <= key_s1;
      sc_s1  <= state_complete;
      sc_s2  <= sc_s1;
    end
  end

  // acceptance happens on the tick that completes the stable interval
  always_comb begin
    db_hit    = '0;
    press_evt = '0;
    for (int k = 0; k < 4; k++) begin
      db_hit[k] = (key_s2[k] != key_acc[k]) &&
                  ((DEBOUNCE_MS == 0) ||
                   (tick_1khz && db_cnt[k] == DB_LAST));
      press_evt[k] = db_hit[k] & key_s2[k];
    end
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      key_acc <= '0;
      for (int k = 0; k < 4; k++) db_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (db_hit[k]) begin
          key_acc[k] <= key_s2[k];
          db_cnt[k]  <= '0;
        end else if (key_s2[k] == key_acc[k]) begin
          db_cnt[k] <= '0;
        end else if (tick_1khz) begin
          db_cnt[k] <= db_cnt[k] + 1'b1;
        end
      end
    end
  end

  always_comb begin
    launch_state = 5'd0;
    priority case (1'b1)
      press_evt[0]: launch_state = 5'd2;
      press_evt[1]: launch_state = 5'd3;
      press_evt[2]: launch_state = 5'd4;
      press_evt[3]: launch_state = 5'd5;
      default:      launch_state = 5'd0;
    endcase
  end

  assign run_exit = (fsm == RUN) &&
                    ((|press_evt) || sc_s2[currentState[2:0]]);

`ifdef STATE_TIMEOUT_EN
  localparam int WW =
    (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_MS - 1);

  logic [WW-1:0] wd_cnt;

  assign wd_hit = (fsm != IDLE) && tick_1khz &&
                  (wd_cnt == WD_LAST);

  // a user exit on the same cycle wins, so the flag stays clear
  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      wd_cnt       <= '0;
      timeout_flag <= 1'b0;
    end else if (fsm == IDLE) begin
      wd_cnt <= '0;
    end else if (wd_hit) begin
      wd_cnt <= '0;
      if (!run_exit) timeout_flag <= 1'b1;
    end else if (tick_1khz) begin
      wd_cnt <= wd_cnt + 1'b1;
    end
  end
`else
  assign wd_hit       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      fsm          <= IDLE;
      currentState <= '0;
      busy         <= 1'b0;
      hold_cnt     <= '0;
      ms_cnt       <= '0;
    end else begin
      if (busy && tick_1khz && ms_cnt != 15'h7fff)
        ms_cnt <= ms_cnt + 1'b1;
      unique case (fsm)
        IDLE: begin
          if (|press_evt) begin
            fsm          <= HOLD;
            currentState <= launch_state;
            busy         <= 1'b1;
            hold_cnt     <= HOLD_INIT;
            ms_cnt       <= '0;
          end
        end
        HOLD: begin
          if (wd_hit) begin
            fsm          <= IDLE;
            currentState <= '0;
            busy         <= 1'b0;
          end else if (hold_cnt == '0) begin
            fsm <= RUN;
          end else if (tick_1khz) begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        RUN: begin
          if (run_exit || wd_hit) begin
            fsm          <= IDLE;
            currentState <= '0;
            busy         <= 1'b0;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

  assign debugString = {timeout_flag, ms_cnt, 7'd0,
                        key_acc, currentState};

endmodule
